mem_stage: RTL

- Pipeline stage directly downstream of the execute-stage ALU.
- Takes the ALU result (`o_res`) plus the memory-op descriptor and performs one load or store against a 64-bit data-memory port.
- Hands the result to writeback: ALU result for non-memory ops, sign/zero-extended load data for loads.
- Single outstanding transaction. Backpressures execute through a valid/ready handshake.

---
 rtl/mem_stage.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage sitting after the execute ALU.
//
// Accepts one op at a time from execute (valid/ready), performs at most one
// load or store on a 64-bit data-memory port, then presents a single-cycle
// writeback result.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), async active-low reset
//   i_valid / o_ready     op handshake from execute; o_ready only in IDLE
//   i_mem_op              0=NONE, 1=LOAD, 2=STORE, 3=reserved (acts as NONE)
//   i_size                0=byte, 1=half, 2=word, 3=double
//   i_unsigned            load zero-extend (1) or sign-extend (0)
//   i_alu_res             ALU result / effective address
//   i_store_data          right-aligned store value
//   i_rd                  destination register
//   o_dmem_*              request, write flag, dword address, byte enables, data
//   i_dmem_gnt            request accepted
//   i_dmem_rvalid/rdata   read response (full 8-byte word)
//   o_wb_*                writeback pulse, write enable, rd and data
//   o_exc_misaligned/addr misaligned-access report, valid with o_wb_valid
module mem_stage #(
   parameter int WIDTH      = 64,
   parameter int ADDR_WIDTH = 64
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [1:0]            i_mem_op,
   input  logic [1:0]            i_size,
   input  logic                  i_unsigned,
   input  logic [WIDTH-1:0]      i_alu_res,
   input  logic [WIDTH-1:0]      i_store_data,
   input  logic [4:0]            i_rd,
   output logic                  o_dmem_req,
   output logic                  o_dmem_we,
   output logic [ADDR_WIDTH-1:0] o_dmem_addr,
   output logic [7:0]            o_dmem_be,
   output logic [WIDTH-1:0]      o_dmem_wdata,
   input  logic                  i_dmem_gnt,
   input  logic                  i_dmem_rvalid,
   input  logic [WIDTH-1:0]      i_dmem_rdata,
   output logic                  o_wb_valid,
   output logic                  o_wb_we,
   output logic [4:0]            o_wb_rd,
   output logic [WIDTH-1:0]      o_wb_data,
   output logic                  o_exc_misaligned,
   output logic [ADDR_WIDTH-1:0] o_exc_addr
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   localparam logic [1:0] OP_LOAD  = 2'd1;
   localparam logic [1:0] OP_STORE = 2'd2;

   state_t                  state;
   state_t                  state_next;
   logic                    capture_load;

   logic                    is_store_r;
   logic [1:0]              size_r;
   logic                    unsigned_r;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [WIDTH-1:0]        store_data_r;
   logic [4:0]              rd_r;
   logic                    fault_r;
   logic                    wb_we_r;
   logic [WIDTH-1:0]        wb_data_r;

   logic                    mem_op_in;
   logic                    misaligned;
   logic                    accept;
   logic [7:0]              base_be;
   logic [WIDTH-1:0]        shifted_rdata;
   logic [WIDTH-1:0]        load_data;

   assign accept    = i_valid && (state == IDLE);
   assign mem_op_in = (i_mem_op == OP_LOAD) || (i_mem_op == OP_STORE);

   // An access must be naturally aligned to its size; bytes can never fault.
   always_comb begin
      misaligned = 1'b0;
      case (i_size)
         2'd1:    misaligned = i_alu_res[0];
         2'd2:    misaligned = |i_alu_res[1:0];
         2'd3:    misaligned = |i_alu_res[2:0];
         default: misaligned = 1'b0;
      endcase
   end

   always_comb begin
      base_be = 8'h01;
      case (size_r)
         2'd1:    base_be = 8'h03;
         2'd2:    base_be = 8'h0F;
         2'd3:    base_be = 8'hFF;
         default: base_be = 8'h01;
      endcase
   end

   // Bring the addressed bytes down to lane 0, then extend to full width.
   // A double fills the whole word so the unsigned flag has no effect there.
   always_comb begin
      shifted_rdata = i_dmem_rdata >> {addr_r[2:0], 3'b000};
      load_data     = shifted_rdata;
      case (size_r)
         2'd0: load_data = unsigned_r ? {{(WIDTH-8){1'b0}}, shifted_rdata[7:0]}
                                      : {{(WIDTH-8){shifted_rdata[7]}}, shifted_rdata[7:0]};
         2'd1: load_data = unsigned_r ? {{(WIDTH-16){1'b0}}, shifted_rdata[15:0]}
                                      : {{(WIDTH-16){shifted_rdata[15]}}, shifted_rdata[15:0]};
         2'd2: load_data = unsigned_r ? {{(WIDTH-32){1'b0}}, shifted_rdata[31:0]}
                                      : {{(WIDTH-32){shifted_rdata[31]}}, shifted_rdata[31:0]};
         default: load_data = shifted_rdata;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Read data is captured on the cycle rvalid is seen in WAIT, or in REQ
   // when the grant and the response arrive together.
   always_comb begin
      state_next   = state;
      capture_load = 1'b0;
      case (state)
         IDLE: begin
            if (i_valid) begin
               if (mem_op_in && !misaligned) state_next = REQ;
               else                          state_next = RESP;
            end
         end
         REQ: begin
            if (i_dmem_gnt) begin
               if (is_store_r) begin
                  state_next = RESP;
               end else if (i_dmem_rvalid) begin
                  state_next   = RESP;
                  capture_load = 1'b1;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (i_dmem_rvalid) begin
               state_next   = RESP;
               capture_load = 1'b1;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Op fields are frozen at accept so execute may change its outputs freely.
   // wb_data_r is only written for pass-through and loads; stores and faults
   // leave the previous result in place.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         is_store_r   <= 1'b0;
         size_r       <= 2'd0;
         unsigned_r   <= 1'b0;
         addr_r       <= '0;
         store_data_r <= '0;
         rd_r         <= 5'd0;
         fault_r      <= 1'b0;
         wb_we_r      <= 1'b0;
         wb_data_r    <= '0;
      end else begin
         if (accept) begin
            is_store_r   <= (i_mem_op == OP_STORE);
            size_r       <= i_size;
            unsigned_r   <= i_unsigned;
            addr_r       <= i_alu_res[ADDR_WIDTH-1:0];
            store_data_r <= i_store_data;
            rd_r         <= i_rd;
            fault_r      <= mem_op_in && misaligned;
            wb_we_r      <= (i_mem_op != OP_STORE) && !(mem_op_in && misaligned);
            if (!mem_op_in) begin
               wb_data_r <= i_alu_res;
            end
         end
         if (capture_load) begin
            wb_data_r <= load_data;
         end
      end
   end

   assign o_ready          = (state == IDLE);
   assign o_dmem_req       = (state == REQ);
   assign o_dmem_we        = o_dmem_req && is_store_r;
   assign o_dmem_addr      = o_dmem_req ? {addr_r[ADDR_WIDTH-1:3], 3'b000} : '0;
   assign o_dmem_be        = o_dmem_req ? (base_be << addr_r[2:0]) : 8'h00;
   assign o_dmem_wdata     = o_dmem_req ? (store_data_r << {addr_r[2:0], 3'b000}) : '0;
   assign o_wb_valid       = (state == RESP);
   assign o_wb_we          = o_wb_valid && wb_we_r;
   assign o_wb_rd          = rd_r;
   assign o_wb_data        = wb_data_r;
   assign o_exc_misaligned = o_wb_valid && fault_r;
   assign o_exc_addr       = o_exc_misaligned ? addr_r : '0;

endmodule
